// File: rtl/stage_memory_pkg.sv
// Shared definitions for the memory-access stage and the bus slave models.
//   REG_NONE         register index meaning "no writeback"
//   BUS_ADDR_W       default bus address width
//   BUS_DATA_W       default bus data / register width
//   BUS_REG_W        default register index width
//   mem_state_t      memory stage FSM state encoding
//   word_aligned()   true when the two low address bits select a word boundary
package stage_memory_pkg;

    localparam int REG_NONE   = 0;
    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_REG_W  = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_t;

    function automatic logic word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/stage_memory.sv
// Memory-access pipeline stage, placed directly after execute.
// ALU results pass through to writeback with one cycle of latency. Aligned
// loads and stores go out on a single-outstanding req/ack bus. Misaligned
// accesses are dropped and flagged with a one-cycle fault pulse.
//
// Ports
//   clk, rst                      clock, async active-high reset
//   in_addr, in_val               execute destination / ALU result (dest 0 = bubble)
//   is_mem, mem_addr, mem_val,
//   mem_write                     execute memory request
//   stall                         freezes upstream while an access is outstanding
//   bus_req, bus_we, bus_addr,
//   bus_wdata                     registered bus request, stable until bus_ack
//   bus_ack, bus_rdata            bus completion and load data
//   fault                         one-cycle pulse for a dropped misaligned access
//   wb_addr, wb_val               writeback register and value (addr 0 = none)
//   fwd_valid, fwd_addr, fwd_val  forwarding tap, wired straight from writeback
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | accepting execute results; a new access may issue
// ST_BUSY | bus request outstanding; inputs ignored, upstream stalled
module stage_memory
    import stage_memory_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W,
    parameter int REG_W  = BUS_REG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  in_addr,
    input  logic [DATA_W-1:0] in_val,
    input  logic              is_mem,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_val,
    input  logic              mem_write,
    output logic              stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              fault,
    output logic [REG_W-1:0]  wb_addr,
    output logic [DATA_W-1:0] wb_val,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_addr,
    output logic [DATA_W-1:0] fwd_val
);

    localparam logic [REG_W-1:0] NO_REG = REG_W'(REG_NONE);

    mem_state_t        state, state_nx;
    logic [REG_W-1:0]  req_dest, req_dest_nx;
    logic              bus_req_nx, bus_we_nx, fault_nx;
    logic [ADDR_W-1:0] bus_addr_nx;
    logic [DATA_W-1:0] bus_wdata_nx, wb_val_nx;
    logic [REG_W-1:0]  wb_addr_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            req_dest  <= NO_REG;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            fault     <= 1'b0;
            wb_addr   <= NO_REG;
            wb_val    <= '0;
        end else begin
            state     <= state_nx;
            req_dest  <= req_dest_nx;
            bus_req   <= bus_req_nx;
            bus_we    <= bus_we_nx;
            bus_addr  <= bus_addr_nx;
            bus_wdata <= bus_wdata_nx;
            fault     <= fault_nx;
            wb_addr   <= wb_addr_nx;
            wb_val    <= wb_val_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        req_dest_nx  = req_dest;
        bus_req_nx   = bus_req;
        bus_we_nx    = bus_we;
        bus_addr_nx  = bus_addr;
        bus_wdata_nx = bus_wdata;
        fault_nx     = 1'b0;
        wb_addr_nx   = wb_addr;
        wb_val_nx    = wb_val;

        case (state)
            ST_IDLE: begin
                if (!is_mem) begin
                    wb_addr_nx = in_addr;
                    wb_val_nx  = in_val;
                end else if (!word_aligned(mem_addr[1:0])) begin
                    fault_nx   = 1'b1;
                    wb_addr_nx = NO_REG;
                end else begin
                    req_dest_nx  = in_addr;
                    bus_we_nx    = mem_write;
                    bus_addr_nx  = {mem_addr[ADDR_W-1:2], 2'b00};
                    bus_wdata_nx = mem_val;
                    bus_req_nx   = 1'b1;
                    wb_addr_nx   = NO_REG;
                    state_nx     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus_ack) begin
                    bus_req_nx = 1'b0;
                    state_nx   = ST_IDLE;
                    if (bus_we) begin
                        wb_addr_nx = NO_REG;
                    end else begin
                        // A load to register 0 still completes on the bus but
                        // lands as "no writeback" because req_dest is 0.
                        wb_addr_nx = req_dest;
                        wb_val_nx  = bus_rdata;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Combinational so upstream is released in the same cycle the ack lands.
    assign stall     = (state == ST_BUSY) && !bus_ack;

    assign fwd_valid = (wb_addr != NO_REG);
    assign fwd_addr  = wb_addr;
    assign fwd_val   = wb_val;

endmodule

// File: tb/tb_stage_memory.sv
// Directed bench for stage_memory: reset, ALU pass-through, waited load,
// zero-wait store, misaligned fault, reset during an access, back-to-back ops.
module tb_stage_memory;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  in_addr = '0;
    logic [31:0] in_val = '0;
    logic        is_mem = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_val = '0;
    logic        mem_write = 1'b0;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        fault;
    logic [3:0]  wb_addr;
    logic [31:0] wb_val;
    logic        fwd_valid;
    logic [3:0]  fwd_addr;
    logic [31:0] fwd_val;

    int n_checks = 0;
    int n_fail   = 0;

    stage_memory #(.ADDR_W(32), .DATA_W(32), .REG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_addr(in_addr), .in_val(in_val),
        .is_mem(is_mem), .mem_addr(mem_addr), .mem_val(mem_val), .mem_write(mem_write),
        .stall(stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .fault(fault),
        .wb_addr(wb_addr), .wb_val(wb_val),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_val(fwd_val)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock and settle 1ns past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        in_addr = 4'd0; in_val = '0; is_mem = 1'b0;
        mem_addr = '0; mem_val = '0; mem_write = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req got %0b exp 0", bus_req); end
        n_checks++; if (bus_we !== 1'b0) begin n_fail++; $display("FAIL reset_bus_we got %0b exp 0", bus_we); end
        n_checks++; if (bus_addr !== 32'h0) begin n_fail++; $display("FAIL reset_bus_addr got %h exp 0", bus_addr); end
        n_checks++; if (bus_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_bus_wdata got %h exp 0", bus_wdata); end
        n_checks++; if (wb_addr !== 4'd0 || wb_val !== 32'h0) begin n_fail++; $display("FAIL reset_wb got %0d/%h exp 0/0", wb_addr, wb_val); end
        n_checks++; if (fault !== 1'b0 || stall !== 1'b0 || fwd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_flags got fault=%0b stall=%0b fwd=%0b exp 0", fault, stall, fwd_valid); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_alu();
        in_addr = 4'd3; in_val = 32'h1234; is_mem = 1'b0;
        step();
        bubble();
        n_checks++; if (wb_addr !== 4'd3 || wb_val !== 32'h1234) begin n_fail++; $display("FAIL alu_wb got %0d/%h exp 3/1234", wb_addr, wb_val); end
        n_checks++; if (fwd_valid !== 1'b1 || fwd_addr !== 4'd3 || fwd_val !== 32'h1234) begin n_fail++; $display("FAIL alu_fwd got %0b/%0d/%h exp 1/3/1234", fwd_valid, fwd_addr, fwd_val); end
        n_checks++; if (stall !== 1'b0 || bus_req !== 1'b0) begin n_fail++; $display("FAIL alu_stall got stall=%0b req=%0b exp 0/0", stall, bus_req); end
        step();
        n_checks++; if (wb_addr !== 4'd0 || fwd_valid !== 1'b0) begin n_fail++; $display("FAIL alu_bubble got %0d/%0b exp 0/0", wb_addr, fwd_valid); end
    endtask

    task automatic test_load_wait();
        int req_cycles;
        int stall_cycles;
        req_cycles = 0;
        stall_cycles = 0;
        in_addr = 4'd5; is_mem = 1'b1; mem_addr = 32'h100; mem_write = 1'b0;
        step();
        bubble();
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin
                bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
                #1;
            end
            if (bus_req === 1'b1) req_cycles++;
            if (stall === 1'b1) stall_cycles++;
            n_checks++; if (bus_addr !== 32'h100 || bus_we !== 1'b0) begin n_fail++; $display("FAIL load_req_hold c%0d got %h/%0b exp 100/0", c, bus_addr, bus_we); end
            n_checks++; if (wb_addr !== 4'd0) begin n_fail++; $display("FAIL load_wb_busy c%0d got %0d exp 0", c, wb_addr); end
            step();
        end
        bus_ack = 1'b0; bus_rdata = '0;
        n_checks++; if (req_cycles !== 3) begin n_fail++; $display("FAIL load_req_cycles got %0d exp 3", req_cycles); end
        n_checks++; if (stall_cycles !== 2) begin n_fail++; $display("FAIL load_stall_cycles got %0d exp 2", stall_cycles); end
        n_checks++; if (wb_addr !== 4'd5 || wb_val !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_wb got %0d/%h exp 5/deadbeef", wb_addr, wb_val); end
        n_checks++; if (bus_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL load_done got req=%0b stall=%0b exp 0/0", bus_req, stall); end
        step();
    endtask

    task automatic test_store_zero_wait();
        in_addr = 4'd7; is_mem = 1'b1; mem_addr = 32'h200; mem_val = 32'hA5A5A5A5; mem_write = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL store_stall_pre got %0b exp 0", stall); end
        step();
        bubble();
        bus_ack = 1'b1;
        #1;
        n_checks++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h200 || bus_wdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL store_req got %0b/%0b/%h/%h exp 1/1/200/a5a5a5a5", bus_req, bus_we, bus_addr, bus_wdata); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL store_stall_ack got %0b exp 0", stall); end
        step();
        bus_ack = 1'b0;
        n_checks++; if (bus_req !== 1'b0 || wb_addr !== 4'd0 || stall !== 1'b0) begin n_fail++; $display("FAIL store_done got req=%0b wb=%0d stall=%0b exp 0/0/0", bus_req, wb_addr, stall); end
        step();
    endtask

    task automatic test_misaligned();
        in_addr = 4'd9; in_val = 32'h99;
        step();
        in_addr = 4'd6; is_mem = 1'b1; mem_addr = 32'h102; mem_write = 1'b0;
        step();
        bubble();
        n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL misalign_fault got %0b exp 1", fault); end
        n_checks++; if (bus_req !== 1'b0 || wb_addr !== 4'd0 || stall !== 1'b0) begin n_fail++; $display("FAIL misalign_state got req=%0b wb=%0d stall=%0b exp 0/0/0", bus_req, wb_addr, stall); end
        step();
        n_checks++; if (fault !== 1'b0 || bus_req !== 1'b0) begin n_fail++; $display("FAIL misalign_pulse got fault=%0b req=%0b exp 0/0", fault, bus_req); end
    endtask

    task automatic test_reset_busy();
        in_addr = 4'd8; is_mem = 1'b1; mem_addr = 32'h40; mem_write = 1'b0;
        step();
        bubble();
        step();
        n_checks++; if (bus_req !== 1'b1 || stall !== 1'b1) begin n_fail++; $display("FAIL rstbusy_pre got req=%0b stall=%0b exp 1/1", bus_req, stall); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (bus_req !== 1'b0 || stall !== 1'b0 || wb_addr !== 4'd0) begin n_fail++; $display("FAIL rstbusy_async got req=%0b stall=%0b wb=%0d exp 0/0/0", bus_req, stall, wb_addr); end
        step();
        rst = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'h12345678;
        step();
        bus_ack = 1'b0; bus_rdata = '0;
        n_checks++; if (wb_addr !== 4'd0 || wb_val !== 32'h0 || bus_req !== 1'b0) begin n_fail++; $display("FAIL rstbusy_late_ack got wb=%0d/%h req=%0b exp 0/0/0", wb_addr, wb_val, bus_req); end
        step();
    endtask

    task automatic test_back_to_back();
        in_addr = 4'd2; is_mem = 1'b1; mem_addr = 32'h10; mem_write = 1'b0;
        step();
        in_addr = 4'd4; in_val = 32'h77; is_mem = 1'b0; mem_addr = '0;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall got %0b exp 1", stall); end
        step();
        bus_ack = 1'b1; bus_rdata = 32'h55AA;
        #1;
        n_checks++; if (stall !== 1'b0 || wb_addr !== 4'd0) begin n_fail++; $display("FAIL b2b_ack_cycle got stall=%0b wb=%0d exp 0/0", stall, wb_addr); end
        step();
        bus_ack = 1'b0; bus_rdata = '0;
        n_checks++; if (wb_addr !== 4'd2 || wb_val !== 32'h55AA) begin n_fail++; $display("FAIL b2b_load_wb got %0d/%h exp 2/55aa", wb_addr, wb_val); end
        step();
        bubble();
        n_checks++; if (wb_addr !== 4'd4 || wb_val !== 32'h77 || fwd_val !== 32'h77) begin n_fail++; $display("FAIL b2b_alu_wb got %0d/%h exp 4/77", wb_addr, wb_val); end
        step();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_wait();
        test_store_zero_wait();
        test_misaligned();
        test_reset_busy();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
